i2s_tran_ctrl: RTL
==================

Name: i2s_tran_ctrl

Overview:
- Transaction scheduler for the master-mode word-select generator.
- Holds a shadow copy of the operating config and starts the generator for a programmed number of frames.
- Asserts stop in time for the generator to finish the last word cleanly, counts completed frames, and reports done, abort and FIFO error status.
- Sits between the register interface and the ws generator/FIFOs.

Parameters:
CNT_W, 16, width of frame-count config and frames_done counter

Ports:
clk  in  1  system clock; all logic on posedge
rst_  in  1  synchronous, active-high reset (asserted = 1)
cfg_we  in  1  write shadow config (cfg_* below)
cfg_mode  in  1  0=MT (transmit), 1=MR (receive)
cfg_stereo  in  1  1=L+R words per frame, 0=L only
cfg_frame32  in  1  1=32-bit words, 0=16-bit (passed through)
cfg_std  in  1  0=I2S, 1=left-justified (passed through)
cfg_nframes  in  CNT_W  frames per transaction
cmd_start  in  1  start pulse
cmd_abort  in  1  abort pulse
tx_empty  in  1  Tx FIFO empty
rx_full  in  1  Rx FIFO full
ws_state  in  2  generator state: 0=IDLE, 1=L, 2=R
word_end  in  1  1-cycle pulse on the last bit-clock of each word
op_mode, op_stereo, op_frame32, op_std  out  1 each  shadow config to generator
op_stop  out  1  stop request to generator
busy  out  1  1 in any state except IDLE
frames_done  out  CNT_W  completed frames in current/last transaction
done_pulse  out  1  1-cycle pulse at transaction end
aborted  out  1  sticky: last transaction ended by abort or early generator stop
err_underrun  out  1  sticky: MT word ended with tx_empty=1
err_overrun  out  1  sticky: MR word ended with rx_full=1
cfg_err  out  1  1-cycle pulse on a rejected write or start

Behaviour:
- Reset values:
  - state=IDLE, op_stop=1, busy=0, frames_done=0, done_pulse=0.
  - aborted, err_underrun, err_overrun and cfg_err all 0.
  - Shadow config: mode=MT, stereo=1, frame32=0, std=I2S, nframes=0.
  - Reset mid-transaction returns to these values immediately.
- op_* outputs are driven only from registered shadow config. Config is accepted only in IDLE. cfg_we outside IDLE is ignored and pulses cfg_err.
- Final-word condition (FW): frames_done==nframes-1 and either ws_state==L with stereo=0, or ws_state==R with stereo=1.
- Frame completion: word_end while ws_state==R (stereo) or ws_state==L (mono). On completion, frames_done increments, saturating at all-ones.
- States:
  - IDLE: op_stop=1.
    - cmd_start with nframes==0: pulse cfg_err and stay in IDLE.
    - cmd_start otherwise: go to ARM; clear frames_done, aborted and both errors.
    - cfg_we and cmd_start in the same cycle: the write lands first and start uses the new values, including the nframes==0 check.
    - cmd_abort is ignored in IDLE.
  - ARM: op_stop=0.
    - Leave when ws_state!=IDLE: to DRAIN if FW holds, else to RUN.
    - cmd_abort: go to DRAIN with aborted=1.
  - RUN: op_stop=0.
    - Count frames on completion.
    - On a word_end where the next word satisfies FW, go to DRAIN so op_stop is 1 before the generator samples at the final boundary.
    - ws_state==IDLE while in RUN (generator stopped on its own): go to DONE, aborted=1.
    - cmd_abort: go to DRAIN, aborted=1.
  - DRAIN: op_stop=1.
    - On word_end, apply frame completion if applicable, then go to DONE.
    - If ws_state is already IDLE, go to DONE without waiting for word_end.
  - DONE: op_stop=1, done_pulse=1 for one cycle, then go to IDLE.
- Error sampling: on every word_end in RUN or DRAIN, set err_underrun if mode=MT and tx_empty=1, and set err_overrun if mode=MR and rx_full=1.
- Simultaneous word_end and cmd_abort in RUN: the count applies and the next state is DRAIN. If that word_end was the final frame's, go directly to DONE with aborted=0.
- Latency: cmd_start to op_stop=0 is 1 cycle. Last word_end to done_pulse is 1 cycle.

Test Plan:
- Stereo, nframes=3, no errors: ws toggles L/R with word_end each word. Expect op_stop rising during frame 3's R word, frames_done=3, done_pulse once, aborted=0.
- Mono, nframes=1: DRAIN entered directly from ARM on ws_state=L. One word_end gives frames_done=1 and done_pulse.
- cmd_start with nframes=0 → cfg_err pulse, busy stays 0. cfg_we while busy → cfg_err pulse, op_* unchanged.
- Abort mid L word, stereo, nframes=5: op_stop=1 next cycle. The L word_end does not count, so frames_done=0, done_pulse fires, aborted=1.
- MT with tx_empty=1 at the 2nd word_end → err_underrun=1 until the next start. MR with rx_full=1 at a word_end → err_overrun=1.
- rst_ asserted in RUN with frames_done=2 → next cycle all outputs at reset values, op_stop=1, shadow config at defaults.

Source files
------------

// File: rtl/i2s_tran_ctrl_if.sv
// Bundle between the register block / ws generator / FIFOs and the transaction controller.
// The slave modport is the controller's view; master is the surrounding system.
interface i2s_tran_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cfg_we;
  logic             cfg_mode;
  logic             cfg_stereo;
  logic             cfg_frame32;
  logic             cfg_std;
  logic [CNT_W-1:0] cfg_nframes;
  logic             cmd_start;
  logic             cmd_abort;
  logic             tx_empty;
  logic             rx_full;
  logic [1:0]       ws_state;
  logic             word_end;
  logic             op_mode;
  logic             op_stereo;
  logic             op_frame32;
  logic             op_std;
  logic             op_stop;
  logic             busy;
  logic [CNT_W-1:0] frames_done;
  logic             done_pulse;
  logic             aborted;
  logic             err_underrun;
  logic             err_overrun;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_mode, cfg_stereo, cfg_frame32, cfg_std, cfg_nframes,
           cmd_start, cmd_abort, tx_empty, rx_full, ws_state, word_end,
    input  op_mode, op_stereo, op_frame32, op_std, op_stop, busy, frames_done,
           done_pulse, aborted, err_underrun, err_overrun, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_mode, cfg_stereo, cfg_frame32, cfg_std, cfg_nframes,
           cmd_start, cmd_abort, tx_empty, rx_full, ws_state, word_end,
    output op_mode, op_stereo, op_frame32, op_std, op_stop, busy, frames_done,
           done_pulse, aborted, err_underrun, err_overrun, cfg_err
  );
endinterface

// File: rtl/i2s_tran_ctrl.sv
// Transaction scheduler for the master-mode I2S word-select generator.
// Shadows the operating config, frames a run of N frames and reports status.
module i2s_tran_ctrl #(
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_,
  i2s_tran_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [1:0] WS_IDLE = 2'd0;
  localparam logic [1:0] WS_L    = 2'd1;
  localparam logic [1:0] WS_R    = 2'd2;

  state_e           state_q;
  logic             op_mode_q, op_stereo_q, op_frame32_q, op_std_q, op_stop_q;
  logic [CNT_W-1:0] nframes_q, frames_done_q;
  logic             done_pulse_q, aborted_q, err_underrun_q, err_overrun_q, cfg_err_q;

  logic             ws_l, ws_r, ws_idle, frame_word, frame_cmp;
  logic             fw_now, fw_next, final_cmp, under_hit, over_hit, in_flight;
  logic [CNT_W-1:0] last_idx, fd_inc, frames_done_d, start_nframes;

  assign ws_l       = (bus.ws_state == WS_L);
  assign ws_r       = (bus.ws_state == WS_R);
  assign ws_idle    = (bus.ws_state == WS_IDLE);
  assign frame_word = op_stereo_q ? ws_r : ws_l;
  assign frame_cmp  = bus.word_end && frame_word;

  assign last_idx      = nframes_q - CNT_W'(1);
  assign fd_inc        = (&frames_done_q) ? frames_done_q : frames_done_q + CNT_W'(1);
  assign frames_done_d = frame_cmp ? fd_inc : frames_done_q;

  // fw_next looks one word ahead: stereo alternates L/R, mono repeats L.
  assign fw_now    = (frames_done_q == last_idx) && frame_word;
  assign fw_next   = (frames_done_d == last_idx) && (op_stereo_q ? ws_l : 1'b1);
  assign final_cmp = frame_cmp && (fd_inc == nframes_q);

  assign start_nframes = bus.cfg_we ? bus.cfg_nframes : nframes_q;
  assign in_flight     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign under_hit     = bus.word_end && !op_mode_q && bus.tx_empty;
  assign over_hit      = bus.word_end && op_mode_q && bus.rx_full;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q        <= S_IDLE;
      op_mode_q      <= 1'b0;
      op_stereo_q    <= 1'b1;
      op_frame32_q   <= 1'b0;
      op_std_q       <= 1'b0;
      nframes_q      <= '0;
      op_stop_q      <= 1'b1;
      frames_done_q  <= '0;
      done_pulse_q   <= 1'b0;
      aborted_q      <= 1'b0;
      err_underrun_q <= 1'b0;
      err_overrun_q  <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      if (bus.cfg_we && (state_q != S_IDLE)) cfg_err_q <= 1'b1;
      if (in_flight && under_hit) err_underrun_q <= 1'b1;
      if (in_flight && over_hit) err_overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.cfg_we) begin
            op_mode_q    <= bus.cfg_mode;
            op_stereo_q  <= bus.cfg_stereo;
            op_frame32_q <= bus.cfg_frame32;
            op_std_q     <= bus.cfg_std;
            nframes_q    <= bus.cfg_nframes;
          end
          if (bus.cmd_start) begin
            if (start_nframes == '0) begin
              cfg_err_q <= 1'b1;
            end else begin
              state_q        <= S_ARM;
              op_stop_q      <= 1'b0;
              frames_done_q  <= '0;
              aborted_q      <= 1'b0;
              err_underrun_q <= 1'b0;
              err_overrun_q  <= 1'b0;
            end
          end
        end
        S_ARM: begin
          if (bus.cmd_abort) begin
            state_q   <= S_DRAIN;
            op_stop_q <= 1'b1;
            aborted_q <= 1'b1;
          end else if (!ws_idle) begin
            if (fw_now) begin
              state_q   <= S_DRAIN;
              op_stop_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          frames_done_q <= frames_done_d;
          // A count that closes the transaction wins over a coincident abort.
          if (ws_idle) begin
            state_q      <= S_DONE;
            op_stop_q    <= 1'b1;
            aborted_q    <= 1'b1;
            done_pulse_q <= 1'b1;
          end else if (final_cmp) begin
            state_q      <= S_DONE;
            op_stop_q    <= 1'b1;
            done_pulse_q <= 1'b1;
          end else if (bus.cmd_abort) begin
            state_q   <= S_DRAIN;
            op_stop_q <= 1'b1;
            aborted_q <= 1'b1;
          end else if (bus.word_end && fw_next) begin
            state_q   <= S_DRAIN;
            op_stop_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (ws_idle) begin
            state_q      <= S_DONE;
            done_pulse_q <= 1'b1;
          end else if (bus.word_end) begin
            frames_done_q <= frames_done_d;
            state_q       <= S_DONE;
            done_pulse_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          op_stop_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.op_mode      = op_mode_q;
  assign bus.op_stereo    = op_stereo_q;
  assign bus.op_frame32   = op_frame32_q;
  assign bus.op_std       = op_std_q;
  assign bus.op_stop      = op_stop_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.frames_done  = frames_done_q;
  assign bus.done_pulse   = done_pulse_q;
  assign bus.aborted      = aborted_q;
  assign bus.err_underrun = err_underrun_q;
  assign bus.err_overrun  = err_overrun_q;
  assign bus.cfg_err      = cfg_err_q;
endmodule
